// File: rtl/rom_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_burst_arbiter_if
//  Description : Requester, ROM and return-path bundle for rom_burst_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_burst_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int LEN_WIDTH  = 5
);
   logic                  r0, r1, r2;
   logic [ADDR_WIDTH-1:0] addr0, addr1, addr2;
   logic [LEN_WIDTH-1:0]  len0, len1, len2;
   logic                  g0, g1, g2;
   logic                  rom_en;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  done;

   // master: requesters plus the ROM data return; slave: the arbiter
   modport master (
      output r0, r1, r2, addr0, addr1, addr2, len0, len1, len2, rom_data,
      input  g0, g1, g2, rom_en, rom_addr, rd_data, rd_valid, done
   );

   modport slave (
      input  r0, r1, r2, addr0, addr1, addr2, len0, len1, len2, rom_data,
      output g0, g1, g2, rom_en, rom_addr, rd_data, rd_valid, done
   );
endinterface
`default_nettype wire

// File: rtl/rom_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_burst_arbiter
//  Description : Round-robin arbiter sharing one synchronous ROM read port
//                among three requesters, issuing a sequential read burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_burst_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int DATA_AMOUNT = 16
) (
   input  logic               clk1,
   input  logic               reset,
   rom_burst_arbiter_if.slave bus
);
   localparam int c_ADDR_W = $clog2(DEPTH);
   localparam int c_LEN_W  = $clog2(DATA_AMOUNT + 1);
   localparam logic [c_LEN_W-1:0]  c_MAX_LEN   = c_LEN_W'(DATA_AMOUNT);
   localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_rr, w_rr_nxt;
   logic [2:0]            r_grant, w_grant_nxt;
   logic                  r_rom_en, w_rom_en_nxt;
   logic [c_ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
   logic [c_LEN_W-1:0]    r_remain, w_remain_nxt;
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rd_hold;

   logic [2:0]            w_req;
   logic [2:0]            w_win;
   logic [1:0]            w_win_rr_nxt;
   logic [c_ADDR_W-1:0]   w_sel_addr;
   logic [c_LEN_W-1:0]    w_sel_len;
   logic [c_LEN_W-1:0]    w_sel_len_clamped;

   assign w_req = {bus.r2, bus.r1, bus.r0};

   // First requester at or after the round-robin pointer wins
   always_comb begin
      w_win = 3'b000;
      case (r_rr)
         2'd1: begin
            if      (w_req[1]) w_win = 3'b010;
            else if (w_req[2]) w_win = 3'b100;
            else if (w_req[0]) w_win = 3'b001;
         end
         2'd2: begin
            if      (w_req[2]) w_win = 3'b100;
            else if (w_req[0]) w_win = 3'b001;
            else if (w_req[1]) w_win = 3'b010;
         end
         default: begin
            if      (w_req[0]) w_win = 3'b001;
            else if (w_req[1]) w_win = 3'b010;
            else if (w_req[2]) w_win = 3'b100;
         end
      endcase
   end

   always_comb begin
      w_sel_addr   = bus.addr0;
      w_sel_len    = bus.len0;
      w_win_rr_nxt = 2'd1;
      if (w_win[1]) begin
         w_sel_addr   = bus.addr1;
         w_sel_len    = bus.len1;
         w_win_rr_nxt = 2'd2;
      end else if (w_win[2]) begin
         w_sel_addr   = bus.addr2;
         w_sel_len    = bus.len2;
         w_win_rr_nxt = 2'd0;
      end
   end

   assign w_sel_len_clamped = (w_sel_len > c_MAX_LEN) ? c_MAX_LEN : w_sel_len;

   // r_remain counts reads still to issue, including the one on the bus now
   always_comb begin
      w_state_nxt    = r_state;
      w_rr_nxt       = r_rr;
      w_grant_nxt    = r_grant;
      w_rom_en_nxt   = 1'b0;
      w_rom_addr_nxt = r_rom_addr;
      w_remain_nxt   = r_remain;
      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_grant_nxt  = w_win;
               w_rr_nxt     = w_win_rr_nxt;
               w_remain_nxt = w_sel_len_clamped;
               if (w_sel_len_clamped != '0) begin
                  w_rom_en_nxt   = 1'b1;
                  w_rom_addr_nxt = w_sel_addr;
                  w_state_nxt    = S_BURST;
               end else begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_BURST: begin
            if (r_remain == c_LEN_W'(1)) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_rom_en_nxt   = 1'b1;
               w_rom_addr_nxt = (r_rom_addr == c_LAST_ADDR) ? '0
                                                             : r_rom_addr + c_ADDR_W'(1);
               w_remain_nxt   = r_remain - c_LEN_W'(1);
            end
         end
         S_DRAIN: begin
            w_grant_nxt = 3'b000;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_grant_nxt = 3'b000;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rr       <= 2'd0;
         r_grant    <= 3'b000;
         r_rom_en   <= 1'b0;
         r_rom_addr <= '0;
         r_remain   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr       <= w_rr_nxt;
         r_grant    <= w_grant_nxt;
         r_rom_en   <= w_rom_en_nxt;
         r_rom_addr <= w_rom_addr_nxt;
         r_remain   <= w_remain_nxt;
      end
   end

   // ROM data arrives one cycle after the issue; keep the last word for the hold behaviour
   always_ff @(posedge clk1) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_hold  <= '0;
      end else begin
         r_rd_valid <= r_rom_en;
         if (r_rd_valid) begin
            r_rd_hold <= bus.rom_data;
         end
      end
   end

   assign bus.g0       = r_grant[0];
   assign bus.g1       = r_grant[1];
   assign bus.g2       = r_grant[2];
   assign bus.rom_en   = r_rom_en;
   assign bus.rom_addr = r_rom_addr;
   assign bus.rd_valid = r_rd_valid;
   assign bus.rd_data  = r_rd_valid ? bus.rom_data : r_rd_hold;
   assign bus.done     = (r_state == S_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_burst_arbiter
//  Description : Directed self-checking bench for rom_burst_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_burst_arbiter;
   localparam logic [7:0] c_IDLE_DATA = 8'hEE;

   logic clk1  = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   logic mon_en   = 1'b0;
   logic [2:0] g_vec;

   rom_burst_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(5)) bus ();

   rom_burst_arbiter #(
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .DATA_AMOUNT(16)
   ) dut (
      .clk1 (clk1),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk1 = ~clk1;

   assign g_vec = {bus.g2, bus.g1, bus.g0};

   // Synchronous ROM holding 0xC0+addr; drives a marker when not read
   always @(posedge clk1) begin
      bus.rom_data <= bus.rom_en ? (8'hC0 + {4'h0, bus.rom_addr}) : c_IDLE_DATA;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk1) begin
      if (mon_en) check_val("onehot", {31'd0, $countones(g_vec) <= 1}, 32'd1);
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_g"},        32'(g_vec),        32'd0);
      check_val({tag, "_rom_en"},   32'(bus.rom_en),   32'd0);
      check_val({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
      check_val({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
      check_val({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
      check_val({tag, "_done"},     32'(bus.done),     32'd0);
   endtask

   // Grant happens at the first edge; checks every cycle through the idle cycle after done
   task automatic expect_burst(input logic [2:0] gexp, input int start, input int len,
                               input logic [2:0] req_after);
      for (int c = 1; c <= len + 1; c++) begin
         tick();
         if (c == 1) {bus.r2, bus.r1, bus.r0} = req_after;
         check_val("grant",    32'(g_vec),        32'(gexp));
         check_val("rom_en",   32'(bus.rom_en),   32'(c <= len));
         if (c <= len)
            check_val("rom_addr", 32'(bus.rom_addr), 32'((start + c - 1) % 16));
         check_val("rd_valid", 32'(bus.rd_valid), 32'(c >= 2));
         if (c >= 2)
            check_val("rd_data", 32'(bus.rd_data), 32'(8'hC0 + (start + c - 2) % 16));
         check_val("done",     32'(bus.done),     32'(c == len + 1));
      end
      tick();
      check_val("idle_g",        32'(g_vec),        32'd0);
      check_val("idle_done",     32'(bus.done),     32'd0);
      check_val("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
      check_val("idle_rom_en",   32'(bus.rom_en),   32'd0);
      if (len > 0)
         check_val("rd_hold", 32'(bus.rd_data), 32'(8'hC0 + (start + len - 1) % 16));
   endtask

   initial begin
      {bus.r2, bus.r1, bus.r0} = 3'b001;
      bus.addr0 = 4'd2;  bus.len0 = 5'd1;
      bus.addr1 = 4'd0;  bus.len1 = 5'd0;
      bus.addr2 = 4'd0;  bus.len2 = 5'd0;

      // Reset held two cycles with r0 pending
      tick();
      check_zero("rst1");
      tick();
      check_zero("rst2");
      reset  = 1'b0;
      mon_en = 1'b1;
      expect_burst(3'b001, 2, 1, 3'b000);

      // Single burst on r1, request dropped right after grant
      bus.r1 = 1'b1; bus.addr1 = 4'd4; bus.len1 = 5'd3;
      expect_burst(3'b010, 4, 3, 3'b000);

      // Zero-length burst on r2
      bus.r2 = 1'b1; bus.addr2 = 4'd3; bus.len2 = 5'd0;
      expect_burst(3'b100, 3, 0, 3'b000);

      // Round robin with all three held, pointer now back at 0
      bus.addr0 = 4'd1; bus.len0 = 5'd2;
      bus.addr1 = 4'd7; bus.len1 = 5'd2;
      bus.addr2 = 4'd15; bus.len2 = 5'd2;
      {bus.r2, bus.r1, bus.r0} = 3'b111;
      expect_burst(3'b001, 1, 2, 3'b111);
      expect_burst(3'b010, 7, 2, 3'b111);
      expect_burst(3'b100, 15, 2, 3'b111);
      expect_burst(3'b001, 1, 2, 3'b000);

      // Wrap and clamp: len 20 trimmed to 16, addresses 14,15,0..13
      bus.r0 = 1'b1; bus.addr0 = 4'd14; bus.len0 = 5'd20;
      expect_burst(3'b001, 14, 16, 3'b000);

      // Drop plus addr/len changes mid-burst must not disturb it
      bus.r0 = 1'b1; bus.addr0 = 4'd9; bus.len0 = 5'd4;
      tick();
      bus.r0 = 1'b0; bus.addr0 = 4'd0; bus.len0 = 5'd1;
      check_val("drop_g",    32'(g_vec),        32'd1);
      check_val("drop_addr", 32'(bus.rom_addr), 32'd9);
      for (int c = 2; c <= 5; c++) begin
         tick();
         check_val("drop_rd_valid", 32'(bus.rd_valid), 32'd1);
         check_val("drop_rd_data",  32'(bus.rd_data),  32'(8'hC0 + 9 + c - 2));
         check_val("drop_done",     32'(bus.done),     32'(c == 5));
      end
      tick();
      check_val("drop_idle_g", 32'(g_vec), 32'd0);

      // Reset on the second read of a 5-word burst
      bus.r1 = 1'b1; bus.addr1 = 4'd8; bus.len1 = 5'd5;
      tick();
      check_val("mid_g", 32'(g_vec), 32'd2);
      tick();
      check_val("mid_addr2", 32'(bus.rom_addr), 32'd9);
      reset = 1'b1;
      tick();
      check_zero("midrst");
      reset = 1'b0;
      expect_burst(3'b010, 8, 5, 3'b000);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
